draw_sprite_engine: RTL and testbench
=====================================

DRAW_SPRITE_ENGINE -- requirements
Module: draw_sprite_engine

Interface
REQ-001 Parameter SPRITE_DIM, default 16: sprite width and height in pixels; must be a power of two.
REQ-002 Parameter COLOUR_W, default 3: width of the pixel colour in bits.
REQ-003 Parameter TRANSPARENT, default 3'b000: colour key; pixels of this colour are never plotted.
REQ-004 clock  input  1  system clock (CLOCK_50); all logic on its rising edge.
REQ-005 resetn  input  1  synchronous, active-low reset.
REQ-006 draw  input  1  level draw request from the control FSM; held high for the whole draw state.
REQ-007 pos_x  input  8  sprite top-left X, screen is 160 wide.
REQ-008 pos_y  input  7  sprite top-left Y, screen is 120 high.
REQ-009 sprite_sel  input  2  selects one of 4 sprite frames in ROM.
REQ-010 rom_addr  output  10  sprite ROM address, {frame, row[3:0], col[3:0]}.
REQ-011 rom_data  input  COLOUR_W  ROM read data, valid one clock after rom_addr (synchronous ROM).
REQ-012 vga_x  output  8  pixel X to the VGA adapter.
REQ-013 vga_y  output  7  pixel Y to the VGA adapter.
REQ-014 vga_colour  output  COLOUR_W  pixel colour to the VGA adapter.
REQ-015 vga_plot  output  1  write strobe to the VGA adapter, one pixel per high cycle.
REQ-016 draw_done  output  1  completion flag back to the control FSM.

Function
REQ-017 FSM states SHALL be S_WAIT, S_RUN, S_FLUSH, S_DONE, S_RELEASE.
REQ-018 In S_WAIT with draw=1, the engine SHALL latch pos_x, pos_y and sprite_sel, clear the 8-bit pixel counter, and go to S_RUN.
REQ-019 Inputs changing after the latch SHALL have no effect on the current draw.
REQ-020 In S_RUN, rom_addr SHALL equal {sel_latched, cnt}; cnt SHALL increment by 1 each cycle, row-major (col=cnt[3:0], row=cnt[7:4]).
REQ-021 On cnt=255 in S_RUN, the FSM SHALL go to S_FLUSH, and cnt SHALL wrap to 0.
REQ-022 A one-stage pipeline register SHALL carry valid, col and row alongside each ROM access.
REQ-023 A pixel SHALL be output one cycle after its address; vga_x=x_latched+col and vga_y=y_latched+row, each computed 9 bits wide.
REQ-024 vga_plot SHALL be 1 only when the staged pixel is valid, rom_data!=TRANSPARENT, sum_x<160 and sum_y<120; vga_colour SHALL equal rom_data.
REQ-025 Off-screen pixels SHALL be clipped and SHALL never wrap onto the screen.
REQ-026 S_FLUSH SHALL last one cycle to emit pixel 255, then the FSM SHALL go to S_DONE.
REQ-027 In S_DONE, draw_done SHALL be 1, and SHALL stay 1 while draw=1.
REQ-028 In S_DONE, when draw=0 the FSM SHALL return to S_WAIT, and draw_done SHALL drop in the same cycle that the state changes.
REQ-029 Timing from draw rising in cycle 0: first address in cycle 1, first plot opportunity in cycle 2, last plot opportunity in cycle 257, draw_done=1 from cycle 258.
REQ-030 If draw falls while in S_RUN or S_FLUSH, the FSM SHALL abort to S_WAIT next cycle; vga_plot SHALL be 0 from that cycle and draw_done SHALL never assert.
REQ-031 After an abort, draw must be 1 again in S_WAIT before a new draw starts.
REQ-032 A draw that stays high after completion SHALL NOT retrigger; S_DONE SHALL hold until draw=0.
REQ-033 The S_RELEASE encoding is reserved; any illegal state SHALL go to S_WAIT.
REQ-034 Outside the plotting cycles, vga_plot SHALL be 0; vga_x, vga_y and vga_colour are don't-care when vga_plot=0.

Reset
REQ-035 With resetn=0 at a clock edge, state SHALL be S_WAIT, cnt=0 and the pipeline valid bit=0.
REQ-036 During reset, vga_plot=0, draw_done=0, rom_addr=0, vga_x=0, vga_y=0 and vga_colour=0.
REQ-037 Reset SHALL take priority over draw, including mid-draw; the next draw after reset restarts from pixel 0.

Verification
REQ-038 Opaque draw: ROM all 3'b101, pos (10,20), sel=1, draw held high -> 256 plots, x 10..25, y 20..35, row-major order, rom_addr 256..511, draw_done in cycle 258.
REQ-039 Transparency: ROM checkerboard of 0 and 3'b111 -> exactly 128 plots; no plot ever has colour 0.
REQ-040 Clipping: pos (150,115), opaque ROM -> plots only for x 150..159 and y 115..119, i.e. 50 plots; no vga_x>=160 and no vga_y>=120.
REQ-041 Abort: draw falls in cycle 100 -> vga_plot=0 from cycle 101; draw_done stays 0; the FSM is in S_WAIT; a following draw produces the full 256 pixels.
REQ-042 Hold-after-done: draw held high 20 cycles past done -> draw_done high for those 20 cycles, no extra plots; draw low -> draw_done=0 the next cycle.
REQ-043 Reset mid-draw: resetn=0 in cycle 50 -> all outputs 0 the next cycle; after release with draw=1, the draw restarts with rom_addr={sel,8'd0}.

Source files
------------

// File: rtl/draw_sprite_engine.sv
// Sprite blitter: walks a SPRITE_DIM x SPRITE_DIM frame of a synchronous sprite ROM and
// emits clipped, colour-keyed pixel writes to the VGA adapter.
module draw_sprite_engine #(
   parameter int unsigned         SPRITE_DIM  = 16,
   parameter int unsigned         COLOUR_W    = 3,
   parameter logic [COLOUR_W-1:0] TRANSPARENT = '0
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  draw,
   input  logic [7:0]            pos_x,
   input  logic [6:0]            pos_y,
   input  logic [1:0]            sprite_sel,
   output logic [2*$clog2(SPRITE_DIM)+1:0] rom_addr,
   input  logic [COLOUR_W-1:0]   rom_data,
   output logic [7:0]            vga_x,
   output logic [6:0]            vga_y,
   output logic [COLOUR_W-1:0]   vga_colour,
   output logic                  vga_plot,
   output logic                  draw_done
);

   localparam int unsigned SIDE_W = $clog2(SPRITE_DIM);
   localparam int unsigned CNT_W  = 2 * SIDE_W;

   typedef enum logic [2:0] {S_WAIT, S_RUN, S_FLUSH, S_DONE, S_RELEASE} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [7:0]          x_q;
   logic [6:0]          y_q;
   logic [1:0]          sel_q;
   logic                valid_q;
   logic [SIDE_W-1:0]   col_q, row_q;
   logic [8:0]          sum_x, sum_y;

   always_ff @(posedge clock) begin
      if (!resetn) state_q <= S_WAIT;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_WAIT:  if (draw) state_d = S_RUN;
         S_RUN: begin
            if (!draw)              state_d = S_WAIT;
            else if (cnt_q == '1)   state_d = S_FLUSH;
         end
         S_FLUSH: state_d = draw ? S_DONE : S_WAIT;
         S_DONE:  if (!draw) state_d = S_WAIT;
         default: state_d = S_WAIT;
      endcase
   end

   // Position/frame latch, pixel counter and the one-stage ROM pipeline.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         cnt_q   <= '0;
         valid_q <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         sel_q   <= '0;
         col_q   <= '0;
         row_q   <= '0;
      end else begin
         // A pixel is only staged if the draw is still requested; this kills it on abort.
         valid_q <= (state_q == S_RUN) && draw;
         if (state_q == S_WAIT && draw) begin
            x_q   <= pos_x;
            y_q   <= pos_y;
            sel_q <= sprite_sel;
            cnt_q <= '0;
         end else if (state_q == S_RUN) begin
            cnt_q <= cnt_q + 1'b1;
            col_q <= cnt_q[SIDE_W-1:0];
            row_q <= cnt_q[CNT_W-1:SIDE_W];
         end
      end
   end

   always_comb begin
      rom_addr   = '0;
      sum_x      = {1'b0, x_q} + 9'(col_q);
      sum_y      = {2'b00, y_q} + 9'(row_q);
      vga_x      = '0;
      vga_y      = '0;
      vga_colour = '0;
      vga_plot   = 1'b0;
      draw_done  = (state_q == S_DONE);
      if (state_q == S_RUN) rom_addr = {sel_q, cnt_q};
      if (valid_q) begin
         vga_x      = sum_x[7:0];
         vga_y      = sum_y[6:0];
         vga_colour = rom_data;
         // Nine-bit sums so off-screen pixels are clipped instead of wrapping.
         vga_plot   = (rom_data != TRANSPARENT) && (sum_x < 9'd160) && (sum_y < 9'd120);
      end
   end

endmodule

// File: tb/tb_draw_sprite_engine.sv
// Self-checking bench for draw_sprite_engine: table-driven draws, random draws against a
// pixel-list reference model, and hand-written abort / hold / reset sequences.
module tb_draw_sprite_engine;

   logic       clock = 1'b0;
   logic       resetn;
   logic       draw;
   logic [7:0] pos_x;
   logic [6:0] pos_y;
   logic [1:0] sprite_sel;
   logic [9:0] rom_addr;
   logic [2:0] rom_data;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;
   logic       draw_done;

   always #5 clock = ~clock;

   draw_sprite_engine dut (
      .clock      (clock),
      .resetn     (resetn),
      .draw       (draw),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .sprite_sel (sprite_sel),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot),
      .draw_done  (draw_done)
   );

   logic [2:0] rom_mem [1024];
   always @(posedge clock) rom_data <= rom_mem[rom_addr];

   typedef struct {int x; int y; int c;} pix_t;
   typedef struct {int px; int py; int sel; int mode; int exp_plots;} vec_t;

   pix_t exp_q[$];
   pix_t got_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   addr_err, first_plot, last_plot;

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // mode 0: all 3'b101, mode 1: checkerboard 0/7, mode 2: random colours
   task automatic fill_rom(input int mode);
      for (int a = 0; a < 1024; a++) begin
         case (mode)
            0:       rom_mem[a] = 3'b101;
            1:       rom_mem[a] = (((a >> 4) + a) % 2 == 1) ? 3'b111 : 3'b000;
            default: rom_mem[a] = 3'($urandom_range(0, 7));
         endcase
      end
   endtask

   // Reference: every opaque, on-screen sprite pixel, in row-major order.
   task automatic build_expected(input int px, input int py, input int sel);
      exp_q.delete();
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++) begin
            pix_t p;
            p.x = px + c;
            p.y = py + r;
            p.c = int'(rom_mem[sel * 256 + r * 16 + c]);
            if (p.c != 0 && p.x < 160 && p.y < 120) exp_q.push_back(p);
         end
   endtask

   task automatic start_draw(input int px, input int py, input int sel);
      @(negedge clock);
      pos_x      = 8'(px);
      pos_y      = 7'(py);
      sprite_sel = 2'(sel);
      draw       = 1'b1;
   endtask

   // Cycle 0 is the cycle in which the engine sees draw=1 in S_WAIT.
   task automatic observe(input int sel, output int done_cycle);
      got_q.delete();
      addr_err   = 0;
      first_plot = -1;
      last_plot  = -1;
      done_cycle = -1;
      for (int c = 1; c <= 300 && done_cycle < 0; c++) begin
         @(negedge clock);
         if (c <= 256 && int'(rom_addr) != sel * 256 + c - 1) addr_err++;
         if (vga_plot) begin
            pix_t p;
            p.x = int'(vga_x);
            p.y = int'(vga_y);
            p.c = int'(vga_colour);
            got_q.push_back(p);
            if (first_plot < 0) first_plot = c;
            last_plot = c;
         end
         if (draw_done) done_cycle = c;
         pos_x      = 8'($urandom);
         pos_y      = 7'($urandom);
         sprite_sel = 2'($urandom);
      end
   endtask

   task automatic check_draw(input string name, input int px, input int py, input int sel,
                             input int done_cycle);
      int bad = 0;
      build_expected(px, py, sel);
      check({name, " plot count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i].x != exp_q[i].x || got_q[i].y != exp_q[i].y || got_q[i].c != exp_q[i].c)
            bad++;
      check({name, " pixel mismatches"}, bad, 0);
      check({name, " rom_addr errors"}, addr_err, 0);
      check({name, " done cycle"}, done_cycle, 258);
      if (got_q.size() > 0) begin
         check({name, " first plot >= cycle 2"}, int'(first_plot >= 2), 1);
         check({name, " last plot <= cycle 257"}, int'(last_plot <= 257), 1);
      end
   endtask

   task automatic end_draw(input string name);
      draw = 1'b0;
      @(negedge clock);
      check({name, " draw_done drop"}, int'(draw_done), 0);
   endtask

   task automatic check_all_zero(input string name);
      check({name, " rom_addr"}, int'(rom_addr), 0);
      check({name, " vga_plot"}, int'(vga_plot), 0);
      check({name, " draw_done"}, int'(draw_done), 0);
      check({name, " vga_xyc"}, int'({vga_x, vga_y, vga_colour}), 0);
   endtask

   initial begin
      vec_t vecs[7];
      int   done_cycle;
      int   cnt, bad;

      vecs[0] = '{px: 10,  py: 20,  sel: 1, mode: 0, exp_plots: 256};
      vecs[1] = '{px: 0,   py: 0,   sel: 2, mode: 1, exp_plots: 128};
      vecs[2] = '{px: 150, py: 115, sel: 0, mode: 0, exp_plots: 50};
      vecs[3] = '{px: 159, py: 119, sel: 3, mode: 0, exp_plots: 1};
      vecs[4] = '{px: 144, py: 104, sel: 1, mode: 0, exp_plots: 256};
      vecs[5] = '{px: 145, py: 105, sel: 2, mode: 0, exp_plots: 225};
      vecs[6] = '{px: 200, py: 10,  sel: 0, mode: 0, exp_plots: 0};

      resetn = 1'b0;
      draw = 1'b0;
      pos_x = '0;
      pos_y = '0;
      sprite_sel = '0;
      fill_rom(0);
      repeat (3) @(negedge clock);
      check_all_zero("reset");
      resetn = 1'b1;
      @(negedge clock);

      foreach (vecs[i]) begin
         fill_rom(vecs[i].mode);
         start_draw(vecs[i].px, vecs[i].py, vecs[i].sel);
         observe(vecs[i].sel, done_cycle);
         check_draw($sformatf("vec%0d", i), vecs[i].px, vecs[i].py, vecs[i].sel, done_cycle);
         check($sformatf("vec%0d table plots", i), got_q.size(), vecs[i].exp_plots);
         if (vecs[i].mode == 1) begin
            cnt = 0;
            foreach (got_q[k]) if (got_q[k].c == 0) cnt++;
            check($sformatf("vec%0d transparent plotted", i), cnt, 0);
         end
         end_draw($sformatf("vec%0d", i));
      end

      // Hold draw high after completion: no retrigger, done stays up.
      fill_rom(0);
      start_draw(40, 50, 3);
      observe(3, done_cycle);
      check_draw("hold", 40, 50, 3, done_cycle);
      cnt = 0;
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         if (draw_done) cnt++;
         if (vga_plot) bad++;
      end
      check("hold done cycles", cnt, 20);
      check("hold extra plots", bad, 0);
      end_draw("hold");

      // Abort: draw falls in cycle 100.
      start_draw(10, 20, 1);
      cnt = 0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clock);
         if (vga_plot) cnt++;
      end
      draw = 1'b0;
      bad = 0;
      for (int c = 101; c <= 110; c++) begin
         @(negedge clock);
         if (vga_plot || draw_done) bad++;
      end
      check("abort plots before", cnt, 99);
      check("abort outputs after", bad, 0);
      start_draw(10, 20, 1);
      observe(1, done_cycle);
      check_draw("after abort", 10, 20, 1, done_cycle);
      end_draw("after abort");

      // Reset in cycle 50 of a draw, then restart with draw still high.
      fill_rom(2);
      start_draw(30, 40, 2);
      for (int c = 1; c <= 50; c++) @(negedge clock);
      resetn = 1'b0;
      @(negedge clock);
      check_all_zero("mid reset");
      resetn = 1'b1;
      pos_x = 8'd30;
      pos_y = 7'd40;
      sprite_sel = 2'd2;
      observe(2, done_cycle);
      check_draw("after reset", 30, 40, 2, done_cycle);
      end_draw("after reset");

      for (int n = 0; n < 8; n++) begin
         int px, py, sel;
         px  = int'($urandom_range(0, 255));
         py  = int'($urandom_range(0, 127));
         sel = int'($urandom_range(0, 3));
         fill_rom(2);
         start_draw(px, py, sel);
         observe(sel, done_cycle);
         check_draw($sformatf("rand%0d", n), px, py, sel, done_cycle);
         end_draw($sformatf("rand%0d", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
